ultra_seq_ctrl: RTL and testbench
=================================

Name: ultra_seq_ctrl

Overview:
- Sequencer between the command decoder and the ultrasonic transducer front-end.
- Consumes the decoder's registered command strobes: on/off, intensity increase/decrease with amount, send, receive, valid.
- Holds the power state and the intensity level.
- Runs timed transmit-burst and listen windows, and drives the TX/RX enables plus status pulses for the host.

Parameters:
AMOUNT_WIDTH, 8, width of amount input and level register
MAX_LEVEL, 200, saturation ceiling for level (must be < 2**AMOUNT_WIDTH)
TX_CYCLES, 16, cycles tx_en stays high per burst (>=1)
RX_CYCLES, 64, cycles rx_en stays high per listen window (>=1)
CNT_WIDTH, 16, width of the window counter (must hold max(TX_CYCLES,RX_CYCLES))

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
valid  in  1  command word strobe from decoder; other inputs sampled only when high
on  in  1  power-on request
off  in  1  power-off / abort request
increase  in  1  raise level by amount
decrease  in  1  lower level by amount
send  in  1  start transmit burst
receive  in  1  start listen window
amount  in  AMOUNT_WIDTH  level step
level  out  AMOUNT_WIDTH  current intensity level
powered  out  1  high in every state except OFF
tx_en  out  1  transmit burst active
rx_en  out  1  listen window active
busy  out  1  high in TX or RX
done  out  1  one-cycle pulse when a sequence completes normally
rejected  out  1  one-cycle pulse when a valid command is ignored

Behaviour:
- Reset (async assert, sync release): state=OFF; level=0; powered, tx_en, rx_en, busy, done, rejected all 0; counter=0.
- All outputs are registered. A command with valid high at edge N is reflected on outputs after edge N; one cycle latency.
- Inputs are ignored when valid=0.
- States: OFF, IDLE, TX, RX.
- OFF:
  - valid&on -> IDLE; all other bits in that word are ignored.
  - valid&!on -> stay OFF, rejected pulse.
- IDLE:
  - valid&off -> OFF, level<=0. No rejected pulse, other bits ignored.
  - Otherwise apply the level update, then:
    - send=1 -> TX (receive also latched as a follow-on flag).
    - Else receive=1 -> RX.
    - Else stay IDLE.
  - A level update and send/receive in the same word both take effect.
  - The on bit in IDLE is a no-op.
- Level arithmetic:
  - Increase: computed in AMOUNT_WIDTH+1 bits; level<=min(level+amount, MAX_LEVEL).
  - Decrease: level<=(amount>level)?0:level-amount.
  - increase&decrease both set: level unchanged (defensive; the decoder should never emit this).
  - amount=0: level unchanged, not rejected.
- TX:
  - tx_en=1 for exactly TX_CYCLES cycles; the counter loads TX_CYCLES-1 on entry and decrements.
  - At count 0: if the follow-on flag is set -> RX (tx_en falls on the same edge rx_en rises, no gap, no overlap).
  - Otherwise -> IDLE with a done pulse.
- RX: rx_en=1 for exactly RX_CYCLES cycles, then -> IDLE with a done pulse. The follow-on flag is cleared.
- busy = (state==TX || state==RX). powered = (state!=OFF).
- During TX/RX:
  - valid&off aborts: -> OFF, level<=0, tx_en/rx_en low next cycle, no done pulse, follow-on flag cleared.
  - Any other valid word: ignored, rejected pulse, level unchanged.
- Simultaneous events:
  - Abort on the final counter cycle wins over completion: no done pulse.
  - A command on the cycle done pulses sees state IDLE only on the next cycle, so it is rejected.
- on&off both set is handled as off in IDLE/TX/RX, and as on in OFF (decoder should never emit this).
- Reset asserted mid-burst: tx_en/rx_en drop immediately (async) and level clears.

Test Plan:
- Power-up/level: reset; valid on; increase amount=150; increase amount=100 -> level 150 then 200 (saturated at MAX_LEVEL); decrease amount=250 -> level 0.
- Burst only: IDLE, valid send -> tx_en high exactly 16 cycles starting the cycle after the command; then IDLE; done high 1 cycle; rx_en never high.
- Burst+listen: valid send+receive -> tx_en 16 cycles, then rx_en 64 cycles with no gap or overlap; busy high for all 80 cycles; a single done pulse.
- Rejection: during RX send valid increase amount=10 -> rejected 1 cycle, level unchanged; in OFF send valid send -> rejected, tx_en stays 0.
- Abort: valid off at TX cycle 5 -> next cycle tx_en=0, powered=0, level=0, no done; repeat with off on the final TX cycle -> no done, no RX.
- Reset mid-sequence: assert rst_n=0 during RX -> rx_en, busy, level go 0 without a clock edge; after release, state is OFF and a send is rejected.

Source files
------------

// File: rtl/ultra_seq_ctrl.sv
// Ultrasonic transducer sequencer: holds power state and intensity level, and runs
// timed transmit-burst / listen windows from registered decoder command strobes.
module ultra_seq_ctrl #(
  parameter int AMOUNT_WIDTH = 8,
  parameter int MAX_LEVEL    = 200,
  parameter int TX_CYCLES    = 16,
  parameter int RX_CYCLES    = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid,
  input  logic                    on,
  input  logic                    off,
  input  logic                    increase,
  input  logic                    decrease,
  input  logic                    send,
  input  logic                    receive,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  output logic [AMOUNT_WIDTH-1:0] level,
  output logic                    powered,
  output logic                    tx_en,
  output logic                    rx_en,
  output logic                    busy,
  output logic                    done,
  output logic                    rejected
);

  typedef enum logic [1:0] {OFF, IDLE, TX, RX} state_t;

  localparam logic [AMOUNT_WIDTH:0]   MAX_EXT  = (AMOUNT_WIDTH+1)'(MAX_LEVEL);
  localparam logic [AMOUNT_WIDTH-1:0] MAX_LVL  = AMOUNT_WIDTH'(MAX_LEVEL);
  localparam logic [CNT_WIDTH-1:0]    TX_LOAD  = CNT_WIDTH'(TX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]    RX_LOAD  = CNT_WIDTH'(RX_CYCLES - 1);

  state_t                  state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    follow;
  logic [AMOUNT_WIDTH:0]   sum;
  logic [AMOUNT_WIDTH-1:0] next_level;

  // One extra bit on the sum so the saturation compare cannot wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sum        = {1'b0, level} + {1'b0, amount};
    next_level = level;
    if (increase && !decrease)
      next_level = (sum > MAX_EXT) ? MAX_LVL : sum[AMOUNT_WIDTH-1:0];
    else if (decrease && !increase)
      next_level = (amount > level) ? '0 : level - amount;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // right-hand side sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      level    <= '0;
      cnt      <= '0;
      follow   <= 1'b0;
      powered  <= 1'b0;
      tx_en    <= 1'b0;
      rx_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rejected <= 1'b0;
    end else begin
      done     <= 1'b0;
      rejected <= 1'b0;
      case (state)
        OFF: begin
          if (valid && on) begin
            state   <= IDLE;
            powered <= 1'b1;
          end else if (valid) begin
            rejected <= 1'b1;
          end
        end

        IDLE: begin
          if (valid && off) begin
            state   <= OFF;
            level   <= '0;
            powered <= 1'b0;
          end else if (valid) begin
            level <= next_level;
            if (send) begin
              state  <= TX;
              cnt    <= TX_LOAD;
              follow <= receive;
              tx_en  <= 1'b1;
              busy   <= 1'b1;
            end else if (receive) begin
              state <= RX;
              cnt   <= RX_LOAD;
              rx_en <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end

        TX, RX: begin
          if (valid && off) begin
            // Abort beats completion, even on the final counter cycle.
            state   <= OFF;
            level   <= '0;
            follow  <= 1'b0;
            powered <= 1'b0;
            tx_en   <= 1'b0;
            rx_en   <= 1'b0;
            busy    <= 1'b0;
          end else begin
            if (valid) rejected <= 1'b1;
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (state == TX && follow) begin
              state  <= RX;
              cnt    <= RX_LOAD;
              follow <= 1'b0;
              tx_en  <= 1'b0;
              rx_en  <= 1'b1;
            end else begin
              state  <= IDLE;
              follow <= 1'b0;
              tx_en  <= 1'b0;
              rx_en  <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
        end

        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_ultra_seq_ctrl.sv
// Directed self-checking bench for ultra_seq_ctrl: power/level arithmetic, burst and
// listen timing, rejection, abort and asynchronous reset behaviour.
module tb_ultra_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0, on = 1'b0, off = 1'b0, increase = 1'b0, decrease = 1'b0;
  logic       send = 1'b0, receive = 1'b0;
  logic [7:0] amount = 8'd0;
  logic [7:0] level;
  logic       powered, tx_en, rx_en, busy, done, rejected;

  int checks = 0;
  int failures = 0;

  int n_tx, n_rx, n_busy, n_done, n_overlap, last_tx, first_rx, last_rx, done_idx;

  ultra_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid),
    .on       (on),
    .off      (off),
    .increase (increase),
    .decrease (decrease),
    .send     (send),
    .receive  (receive),
    .amount   (amount),
    .level    (level),
    .powered  (powered),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .busy     (busy),
    .done     (done),
    .rejected (rejected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: presents one command word for the next rising edge and
  // returns at the following falling edge, where the outputs reflect that command.
  task automatic cmd(input logic c_on, c_off, c_inc, c_dec, c_send, c_recv,
                     input logic [7:0] amt);
    valid = 1'b1; on = c_on; off = c_off; increase = c_inc; decrease = c_dec;
    send = c_send; receive = c_recv; amount = amt;
    @(negedge clk);
    valid = 1'b0; on = 1'b0; off = 1'b0; increase = 1'b0; decrease = 1'b0;
    send = 1'b0; receive = 1'b0; amount = 8'd0;
  endtask

  // Samples n consecutive falling edges, starting with the current one.
  task automatic window(input int n);
    n_tx = 0; n_rx = 0; n_busy = 0; n_done = 0; n_overlap = 0;
    last_tx = -1; first_rx = -1; last_rx = -1; done_idx = -1;
    for (int i = 0; i < n; i++) begin
      if (tx_en) begin n_tx++; last_tx = i; end
      if (rx_en) begin n_rx++; last_rx = i; if (first_rx < 0) first_rx = i; end
      if (busy) n_busy++;
      if (done) begin n_done++; done_idx = i; end
      if (tx_en && rx_en) n_overlap++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_level", level, 0);
    check("rst_powered", powered, 0);
    check("rst_tx", tx_en, 0);
    check("rst_rx", rx_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rej", rejected, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Power-up and level arithmetic
    cmd(1, 0, 0, 0, 0, 0, 8'd0);
    check("on_powered", powered, 1);
    check("on_busy", busy, 0);
    check("on_rej", rejected, 0);
    cmd(0, 0, 1, 0, 0, 0, 8'd150);
    check("inc150", level, 150);
    cmd(0, 0, 1, 0, 0, 0, 8'd100);
    check("inc_sat", level, 200);
    cmd(0, 0, 0, 1, 0, 0, 8'd250);
    check("dec_floor", level, 0);
    cmd(0, 0, 1, 0, 0, 0, 8'd30);
    check("inc30", level, 30);
    cmd(0, 0, 0, 1, 0, 0, 8'd12);
    check("dec12", level, 18);
    cmd(0, 0, 1, 1, 0, 0, 8'd50);
    check("incdec_hold", level, 18);
    cmd(0, 0, 1, 0, 0, 0, 8'd0);
    check("amt0_level", level, 18);
    check("amt0_rej", rejected, 0);
    cmd(1, 0, 0, 0, 0, 0, 8'd0);
    check("on_idle_noop", powered, 1);

    // Burst only
    cmd(0, 0, 0, 0, 1, 0, 8'd0);
    check("tx_first", tx_en, 1);
    window(30);
    check("burst_tx_cycles", n_tx, 16);
    check("burst_tx_last", last_tx, 15);
    check("burst_rx_cycles", n_rx, 0);
    check("burst_busy", n_busy, 16);
    check("burst_done_n", n_done, 1);
    check("burst_done_at", done_idx, 16);
    check("burst_powered", powered, 1);

    // Burst + listen, with a level update in the same word
    cmd(0, 0, 1, 0, 1, 1, 8'd7);
    check("bl_level", level, 25);
    window(100);
    check("bl_tx", n_tx, 16);
    check("bl_rx", n_rx, 64);
    check("bl_first_rx", first_rx, 16);
    check("bl_last_rx", last_rx, 79);
    check("bl_overlap", n_overlap, 0);
    check("bl_busy", n_busy, 80);
    check("bl_done_n", n_done, 1);
    check("bl_done_at", done_idx, 80);

    // Command presented on the completion edge is rejected
    cmd(0, 0, 0, 0, 1, 0, 8'd0);
    repeat (15) @(negedge clk);
    cmd(0, 0, 1, 0, 0, 0, 8'd5);
    check("edge_done", done, 1);
    check("edge_rej", rejected, 1);
    check("edge_level", level, 25);
    check("edge_tx", tx_en, 0);

    // Rejection during RX, then abort from RX
    cmd(0, 0, 0, 0, 0, 1, 8'd0);
    check("rx_start", rx_en, 1);
    check("rx_tx_low", tx_en, 0);
    repeat (3) @(negedge clk);
    cmd(0, 0, 1, 0, 0, 0, 8'd10);
    check("rx_rej", rejected, 1);
    check("rx_rej_level", level, 25);
    check("rx_still", rx_en, 1);
    @(negedge clk);
    check("rx_rej_pulse", rejected, 0);
    cmd(0, 1, 0, 0, 0, 0, 8'd0);
    check("rx_abort_rx", rx_en, 0);
    check("rx_abort_pwr", powered, 0);
    check("rx_abort_level", level, 0);
    check("rx_abort_done", done, 0);

    // Send while OFF is rejected
    cmd(0, 0, 0, 0, 1, 0, 8'd0);
    check("off_send_rej", rejected, 1);
    check("off_send_tx", tx_en, 0);
    check("off_send_pwr", powered, 0);

    // on&off together while OFF acts as on; in IDLE acts as off
    cmd(1, 1, 0, 0, 0, 0, 8'd0);
    check("onoff_off", powered, 1);
    cmd(1, 1, 0, 0, 0, 0, 8'd0);
    check("onoff_idle", powered, 0);
    check("onoff_idle_rej", rejected, 0);

    // Abort at TX cycle 5
    cmd(1, 0, 0, 0, 0, 0, 8'd0);
    cmd(0, 0, 1, 0, 1, 0, 8'd40);
    check("ab5_level_pre", level, 40);
    repeat (4) @(negedge clk);
    check("ab5_tx_pre", tx_en, 1);
    cmd(0, 1, 0, 0, 0, 0, 8'd0);
    check("ab5_tx", tx_en, 0);
    check("ab5_pwr", powered, 0);
    check("ab5_level", level, 0);
    check("ab5_busy", busy, 0);
    window(20);
    check("ab5_done", n_done, 0);
    check("ab5_tx_after", n_tx, 0);

    // Abort on the final TX cycle with a listen follow-on pending
    cmd(1, 0, 0, 0, 0, 0, 8'd0);
    cmd(0, 0, 0, 0, 1, 1, 8'd0);
    repeat (15) @(negedge clk);
    check("abf_tx_pre", tx_en, 1);
    cmd(0, 1, 0, 0, 0, 0, 8'd0);
    check("abf_tx", tx_en, 0);
    check("abf_rx", rx_en, 0);
    check("abf_done", done, 0);
    window(10);
    check("abf_rx_after", n_rx, 0);
    check("abf_done_after", n_done, 0);

    // Asynchronous reset during RX
    cmd(1, 0, 0, 0, 0, 0, 8'd0);
    cmd(0, 0, 1, 0, 0, 1, 8'd60);
    repeat (10) @(negedge clk);
    check("ar_rx_pre", rx_en, 1);
    check("ar_level_pre", level, 60);
    #2 rst_n = 1'b0;
    #1;
    check("ar_rx", rx_en, 0);
    check("ar_busy", busy, 0);
    check("ar_level", level, 0);
    check("ar_pwr", powered, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd(0, 0, 0, 0, 1, 0, 8'd0);
    check("ar_send_rej", rejected, 1);
    check("ar_send_tx", tx_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
